// File: rtl/ppl_pkg.sv
// Shared pipeline package: default widths, the r0 index constant and the
// register-index / data-word typedefs used by the pipeline-register,
// forwarding and register-file blocks.
package ppl_pkg;

  localparam int PPL_DATA_W = 32;
  localparam int PPL_ADDR_W = 5;

  typedef logic [PPL_ADDR_W-1:0] reg_idx_t;
  typedef logic [PPL_DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/ppl_wb_regfile_if.sv
// MEM/WB to register-file bundle plus the D-stage read ports.
//   master : pipeline side (drives W-stage bundle and read indices)
//   slave  : register file (drives read data and commit counter)
// Signals:
//   wWriteReg / wReg / wDataImm : W-stage write enable, index, data
//   dRs / dRt                   : D-stage read indices
//   dQa / dQb                   : D-stage read data
//   wbCount                     : committed non-r0 write counter
// Optional (PPL_RF_DEBUG_PORT_EN): dbgReg / dbgQ debug read port.
interface ppl_wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              wWriteReg;
  logic [ADDR_W-1:0] wReg;
  logic [DATA_W-1:0] wDataImm;
  logic [ADDR_W-1:0] dRs;
  logic [ADDR_W-1:0] dRt;
  logic [DATA_W-1:0] dQa;
  logic [DATA_W-1:0] dQb;
  logic [CNT_W-1:0]  wbCount;
`ifdef PPL_RF_DEBUG_PORT_EN
  logic [ADDR_W-1:0] dbgReg;
  logic [DATA_W-1:0] dbgQ;

  modport master (
    output wWriteReg, wReg, wDataImm, dRs, dRt, dbgReg,
    input  dQa, dQb, wbCount, dbgQ
  );
  modport slave (
    input  wWriteReg, wReg, wDataImm, dRs, dRt, dbgReg,
    output dQa, dQb, wbCount, dbgQ
  );
`else
  modport master (
    output wWriteReg, wReg, wDataImm, dRs, dRt,
    input  dQa, dQb, wbCount
  );
  modport slave (
    input  wWriteReg, wReg, wDataImm, dRs, dRt,
    output dQa, dQb, wbCount
  );
`endif
endinterface

// File: rtl/ppl_rf_readport.sv
// One register-file read port: forces r0 to zero and, when BYPASS!=0,
// returns the in-flight W-stage data for a matching index.
// Ports:
//   i_idx      read index
//   i_row      array contents at i_idx
//   i_wr_en    W-stage write enable
//   i_wr_idx   W-stage destination index
//   i_wr_data  W-stage write-back data
//   o_q        read data (combinational)
module ppl_rf_readport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_row,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_q
);

  logic w_hit;

  // i_idx != 0 already implies the write index is non-zero on a hit.
  assign w_hit = (BYPASS != 0) && i_wr_en && (i_wr_idx == i_idx);

  always_comb begin
    o_q = i_row;
    if (i_idx == '0)
      o_q = '0;
    else if (w_hit)
      o_q = i_wr_data;
  end

endmodule

// File: rtl/ppl_wb_regfile.sv
// Write-back end of the MEM/WB interface: commits the W-stage bundle into
// a 2**ADDR_W entry GPR file (r0 hard-wired to zero), serves the D-stage
// rs/rt reads with optional same-cycle W->D bypass, and counts committed
// non-r0 writes.
// Ports:
//   clk    pipeline clock, rising edge
//   reset  asynchronous active-high reset (clears array and counter)
//   bus    ppl_wb_regfile_if.slave (W-stage bundle, read ports, wbCount)
// Optional feature macro: PPL_RF_DEBUG_PORT_EN adds the dbgReg/dbgQ
// non-bypassed debug read port.
module ppl_wb_regfile
  import ppl_pkg::*;
#(
  parameter int DATA_W = PPL_DATA_W,
  parameter int ADDR_W = PPL_ADDR_W,
  parameter int CNT_W  = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  ppl_wb_regfile_if.slave   bus
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [CNT_W-1:0]  r_cnt;

  logic              w_commit;
  logic [DATA_W-1:0] w_qa;
  logic [DATA_W-1:0] w_qb;

  assign w_commit = bus.wWriteReg && (bus.wReg != '0);

  // Entry 0 is cleared on reset and never written, so the array itself
  // never holds a non-zero r0; the read ports force it regardless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++)
        r_mem[i] <= '0;
      r_cnt <= '0;
    end else if (w_commit) begin
      r_mem[bus.wReg] <= bus.wDataImm;
      r_cnt           <= r_cnt + CNT_W'(1);
    end
  end

  ppl_rf_readport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_a (
    .i_idx     (bus.dRs),
    .i_row     (r_mem[bus.dRs]),
    .i_wr_en   (bus.wWriteReg),
    .i_wr_idx  (bus.wReg),
    .i_wr_data (bus.wDataImm),
    .o_q       (w_qa)
  );

  ppl_rf_readport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_b (
    .i_idx     (bus.dRt),
    .i_row     (r_mem[bus.dRt]),
    .i_wr_en   (bus.wWriteReg),
    .i_wr_idx  (bus.wReg),
    .i_wr_data (bus.wDataImm),
    .o_q       (w_qb)
  );

  assign bus.dQa     = w_qa;
  assign bus.dQb     = w_qb;
  assign bus.wbCount = r_cnt;

`ifdef PPL_RF_DEBUG_PORT_EN
  logic [DATA_W-1:0] w_qdbg;

  ppl_rf_readport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0)) u_rd_dbg (
    .i_idx     (bus.dbgReg),
    .i_row     (r_mem[bus.dbgReg]),
    .i_wr_en   (bus.wWriteReg),
    .i_wr_idx  (bus.wReg),
    .i_wr_data (bus.wDataImm),
    .o_q       (w_qdbg)
  );

  assign bus.dbgQ = w_qdbg;
`endif

endmodule

// File: tb/tb_ppl_wb_regfile.sv
// Self-checking bench for ppl_wb_regfile. Two instances share one stimulus
// stream: u_dut_a (defaults: BYPASS=1, CNT_W=32) and u_dut_b (BYPASS=0,
// CNT_W=4). Expected values come from a plain array/counter model.
module tb_ppl_wb_regfile;
  import ppl_pkg::*;

  logic clk;
  logic reset;

  ppl_wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) ifa ();
  ppl_wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  ifb ();

  ppl_wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32), .BYPASS(1)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  ppl_wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4), .BYPASS(0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [31:0] mem [32];
  int unsigned cnt;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp,
                                         input logic we, input logic [4:0] wr,
                                         input logic [31:0] d);
    if (idx == 5'd0)                   return 32'h0;
    if (byp && we && (wr == idx))      return d;
    return mem[idx];
  endfunction

  task automatic drive(input logic we, input logic [4:0] rg, input logic [31:0] d,
                       input logic [4:0] rs, input logic [4:0] rt);
    ifa.wWriteReg = we; ifa.wReg = rg; ifa.wDataImm = d; ifa.dRs = rs; ifa.dRt = rt;
    ifb.wWriteReg = we; ifb.wReg = rg; ifb.wDataImm = d; ifb.dRs = rs; ifb.dRt = rt;
`ifdef PPL_RF_DEBUG_PORT_EN
    ifa.dbgReg = rs; ifb.dbgReg = rt;
`endif
  endtask

  // One pipeline cycle: present inputs, check combinational reads and the
  // registered counter before the edge, then advance the model on the edge.
  task automatic cycle(input logic we, input logic [4:0] rg, input logic [31:0] d,
                       input logic [4:0] rs, input logic [4:0] rt);
    drive(we, rg, d, rs, rt);
    #2;
    chk("a_dQa", ifa.dQa, exp_rd(rs, 1'b1, we, rg, d));
    chk("a_dQb", ifa.dQb, exp_rd(rt, 1'b1, we, rg, d));
    chk("b_dQa", ifb.dQa, exp_rd(rs, 1'b0, we, rg, d));
    chk("b_dQb", ifb.dQb, exp_rd(rt, 1'b0, we, rg, d));
    chk("a_cnt", ifa.wbCount, cnt);
    chk("b_cnt", {28'h0, ifb.wbCount}, cnt % 16);
`ifdef PPL_RF_DEBUG_PORT_EN
    chk("a_dbg", ifa.dbgQ, exp_rd(rs, 1'b0, we, rg, d));
    chk("b_dbg", ifb.dbgQ, exp_rd(rt, 1'b0, we, rg, d));
`endif
    @(posedge clk);
    if (we && rg != 5'd0) begin
      mem[rg] = d;
      cnt++;
    end
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    cnt = 0;
  endtask

  int unsigned saved_cnt;
  logic        r_we;
  logic [4:0]  r_rg, r_rs, r_rt;
  logic [31:0] r_d;

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // All indices read zero after reset
    for (int i = 0; i < 32; i += 2)
      cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
    chk("rst_cnt", ifa.wbCount, 32'd0);

    // Basic commit and next-cycle read
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd1);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    chk("r5_val", ifa.dQa, 32'hDEADBEEF);
    chk("r5_cnt", ifa.wbCount, 32'd1);

    // Same-cycle bypass on both ports
    cycle(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    drive(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
    #1;
    chk("byp_a", ifa.dQa, 32'h22222222);
    chk("byp_b", ifa.dQb, 32'h22222222);
    chk("nobyp_a", ifb.dQa, 32'h11111111);
    chk("nobyp_b", ifb.dQb, 32'h11111111);
    #1;
    cycle(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Write to r0 dropped and not counted
    saved_cnt = cnt;
    cycle(1'b1, REG_ZERO, 32'hFFFFFFFF, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("r0_val", ifa.dQa, 32'h0);
    chk("r0_cnt", ifa.wbCount, saved_cnt);

    // wWriteReg=0 leaves array and counter alone
    cycle(1'b1, 5'd9, 32'h99999999, 5'd0, 5'd0);
    saved_cnt = cnt;
    cycle(1'b0, 5'd9, 32'hABCD0000, 5'd9, 5'd9);
    cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    chk("we0_val", ifa.dQa, 32'h99999999);
    chk("we0_cnt", ifa.wbCount, saved_cnt);

    // Reset mid-write: pending r3 commit is lost
    cycle(1'b1, 5'd3, 32'h33333333, 5'd0, 5'd0);
    drive(1'b1, 5'd3, 32'h44444444, 5'd3, 5'd3);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_cnt", ifa.wbCount, 32'd0);
    @(posedge clk);
    #1 drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    chk("rst_r3", ifa.dQa, 32'h0);
    chk("rst_cnt2", ifa.wbCount, 32'd0);

    // Counter wrap on the CNT_W=4 instance
    for (int i = 0; i < 17; i++)
      cycle(1'b1, 5'(1 + (i % 31)), $urandom, 5'(i), 5'(31 - i));
    cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    chk("wrap_b", {28'h0, ifb.wbCount}, 32'd1);
    chk("wrap_a", ifa.wbCount, 32'd17);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      r_we = 1'($urandom_range(0, 1));
      r_rg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r_d  = $urandom;
      r_rs = ($urandom_range(0, 2) == 0) ? r_rg : 5'($urandom_range(0, 31));
      r_rt = ($urandom_range(0, 2) == 0) ? r_rg : 5'($urandom_range(0, 31));
      cycle(r_we, r_rg, r_d, r_rs, r_rt);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
